// File: rtl/jk_mod_counter_pkg.sv
// jk_mod_counter_pkg
//   Shared definitions for the JK-based modulo counter.
//   JK cell modes are encoded as {J,K}:
//     JK_HOLD 2'b00  keep current bit
//     JK_RST  2'b01  clear bit
//     JK_SET  2'b10  set bit
//     JK_TGL  2'b11  invert bit
package jk_mod_counter_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_mode_e;

    function automatic jk_mode_e jk_mode(input logic j, input logic k);
        return jk_mode_e'({j, k});
    endfunction

endpackage

// File: rtl/jk_mod_counter_jk_stage.sv
// jk_stage
//   One JK flip-flop cell with synchronous active-low reset.
//   Ports:
//     Cp  in  clock, rising edge
//     R   in  synchronous reset, active-low (clears Q)
//     J   in  J input
//     K   in  K input
//     Q   out registered bit
module jk_stage
    import jk_mod_counter_pkg::*;
(
    input  logic Cp,
    input  logic R,
    input  logic J,
    input  logic K,
    output logic Q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        unique case (jk_mode(J, K))
            JK_HOLD: q_d = q_q;
            JK_RST:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            JK_TGL:  q_d = ~q_q;
        endcase
    end

    always_ff @(posedge Cp) begin
        if (!R) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter
//   Synchronous modulo-MODULO up/down counter built from WIDTH JK cells.
//   Priority at each rising Cp: reset > load > count > hold.
//   Ports:
//     Cp   in   clock, rising edge
//     R    in   synchronous reset, active-low
//     En   in   count enable
//     Up   in   direction, 1 = up, 0 = down
//     Ld   in   parallel load strobe
//     D    in   parallel load value
//     Q    out  current count (registered)
//     Co   out  cascade carry/borrow (combinational)
//     Err  out  illegal-load flag, one-cycle pulse (registered)
module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic             Cp,
    input  logic             R,
    input  logic             En,
    input  logic             Up,
    input  logic             Ld,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Co,
    output logic             Err
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);
    // One extra bit so MODULO == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0] q_cur;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             d_illegal;
    logic             q_out_of_range;
    logic             err_q;
    logic             err_d;

    assign d_illegal      = ({1'b0, D} >= MOD_EXT);
    assign q_out_of_range = ({1'b0, q_cur} >= MOD_EXT);

    // Next count value including wrap; an out-of-range state recovers to 0.
    always_comb begin
        cnt_nxt = q_cur;
        if (q_out_of_range) begin
            cnt_nxt = '0;
        end else if (Up) begin
            cnt_nxt = (q_cur == CNT_MAX) ? '0 : q_cur + 1'b1;
        end else begin
            cnt_nxt = (q_cur == '0) ? CNT_MAX : q_cur - 1'b1;
        end
    end

    // J/K decode per bit: counting toggles exactly the bits that differ.
    always_comb begin
        j_vec = '0;
        k_vec = '0;
        if (!R) begin
            j_vec = '0;
            k_vec = '1;
        end else if (Ld) begin
            if (d_illegal) begin
                j_vec = '0;
                k_vec = '1;
            end else begin
                j_vec = D;
                k_vec = ~D;
            end
        end else if (En) begin
            j_vec = q_cur ^ cnt_nxt;
            k_vec = q_cur ^ cnt_nxt;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_stage
            jk_stage u_stage (
                .Cp (Cp),
                .R  (R),
                .J  (j_vec[gi]),
                .K  (k_vec[gi]),
                .Q  (q_cur[gi])
            );
        end
    endgenerate

    assign err_d = R & Ld & d_illegal;

    always_ff @(posedge Cp) begin
        if (!R) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign Q   = q_cur;
    assign Err = err_q;
    assign Co  = En & ~Ld & (Up ? (q_cur == CNT_MAX) : (q_cur == '0));

endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;

    typedef struct {
        logic       r;
        logic       en;
        logic       up;
        logic       ld;
        logic [3:0] d;
        logic       co;
        logic [3:0] q;
        logic       err;
        string      name;
    } vec_t;

    typedef struct {
        logic [7:0] val;
        logic       err;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       r, en, up, ld;
    logic [3:0] d;
    logic [3:0] q;
    logic       co, err;

    logic       c_r, c_en;
    logic [3:0] q0, q1, qh;
    logic       co0, co1, coh, err0, err1, errh;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(4), .MODULO(10)) u_dut (
        .Cp(clk), .R(r), .En(en), .Up(up), .Ld(ld), .D(d),
        .Q(q), .Co(co), .Err(err)
    );

    jk_mod_counter #(.WIDTH(4), .MODULO(10)) u_d0 (
        .Cp(clk), .R(c_r), .En(c_en), .Up(1'b1), .Ld(1'b0), .D(4'd0),
        .Q(q0), .Co(co0), .Err(err0)
    );

    jk_mod_counter #(.WIDTH(4), .MODULO(10)) u_d1 (
        .Cp(clk), .R(c_r), .En(co0), .Up(1'b1), .Ld(1'b0), .D(4'd0),
        .Q(q1), .Co(co1), .Err(err1)
    );

    jk_mod_counter #(.WIDTH(4), .MODULO(16)) u_hex (
        .Cp(clk), .R(c_r), .En(c_en), .Up(1'b1), .Ld(1'b0), .D(4'd0),
        .Q(qh), .Co(coh), .Err(errh)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic rr, input logic e, input logic u, input logic l,
                                input logic [3:0] dd, input logic c, input logic [3:0] qq,
                                input logic ee, input string nm);
        vec_t v;
        v.r = rr; v.en = e; v.up = u; v.ld = l; v.d = dd;
        v.co = c; v.q = qq; v.err = ee; v.name = nm;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        r = 1'b0; en = 1'b0; up = 1'b0; ld = 1'b0; d = 4'd0;
        c_r = 1'b0; c_en = 1'b0;

        // Reset overrides load and count.
        add(0, 1, 1, 1, 4'd5, 0, 4'd0, 0, "rst_over_ld");
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 4'd0, 0, 4'd0, 0, "hold_after_rst");
        // Count up 12 edges from 0; Co only while Q==9.
        for (int i = 0; i < 12; i++)
            add(1, 1, 1, 0, 4'd0, (i == 9), 4'((i + 1) % 10), 0, "count_up");
        // Load 0, then count down with wrap.
        add(1, 0, 0, 1, 4'd0, 0, 4'd0, 0, "load_0");
        add(1, 1, 0, 0, 4'd0, 1, 4'd9, 0, "down_wrap");
        add(1, 1, 0, 0, 4'd0, 0, 4'd8, 0, "down_8");
        add(1, 1, 0, 0, 4'd0, 0, 4'd7, 0, "down_7");
        // Load beats count; illegal loads flag for one cycle.
        add(1, 1, 0, 1, 4'd7, 0, 4'd7, 0, "load_7");
        add(1, 0, 0, 1, 4'd12, 0, 4'd0, 1, "load_12_err");
        add(1, 0, 0, 0, 4'd0, 0, 4'd0, 0, "err_clears");
        add(1, 0, 0, 1, 4'd9, 0, 4'd9, 0, "load_9_ok");
        add(1, 1, 1, 1, 4'd3, 0, 4'd3, 0, "ld_masks_co");
        add(1, 0, 1, 1, 4'd10, 0, 4'd0, 1, "load_10_err");
        add(1, 0, 1, 1, 4'd15, 0, 4'd0, 1, "load_15_err");
        add(1, 0, 0, 0, 4'd0, 0, 4'd0, 0, "err_clears2");
        add(1, 0, 0, 1, 4'd11, 0, 4'd0, 1, "load_11_err");
        add(0, 0, 0, 1, 4'd12, 0, 4'd0, 0, "rst_clears_err");
        // Mid-count reset then resume.
        for (int i = 0; i < 6; i++) add(1, 1, 1, 0, 4'd0, 0, 4'(i + 1), 0, "up_to_6");
        add(0, 1, 1, 0, 4'd0, 0, 4'd0, 0, "mid_rst");
        add(1, 1, 1, 0, 4'd0, 0, 4'd1, 0, "resume_1");
        add(1, 1, 1, 0, 4'd0, 0, 4'd2, 0, "resume_2");
        // Co on Up=1 at max, En=1 without load.
        add(1, 0, 0, 1, 4'd9, 0, 4'd9, 0, "load_9b");
        add(1, 1, 1, 0, 4'd0, 1, 4'd0, 0, "up_wrap_co");
        add(1, 0, 1, 0, 4'd0, 0, 4'd0, 0, "co_needs_en");

        foreach (vecs[i]) begin
            @(negedge clk);
            r = vecs[i].r; en = vecs[i].en; up = vecs[i].up; ld = vecs[i].ld; d = vecs[i].d;
            e.val = {4'd0, vecs[i].q}; e.err = vecs[i].err; e.name = vecs[i].name;
            sb.push_back(e);
            #1;
            check({vecs[i].name, "_co"}, 32'(co), 32'(vecs[i].co));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check({e.name, "_q"}, 32'(q), 32'(e.val));
            check({e.name, "_err"}, 32'(err), 32'(e.err));
        end

        // Cascaded decade pair and a hex counter, stepped together.
        @(negedge clk);
        c_r = 1'b0; c_en = 1'b1;
        @(posedge clk);
        #1;
        check("cas_rst", 32'({q1, q0}), 32'd0);
        check("hex_rst", 32'(qh), 32'd0);
        @(negedge clk);
        c_r = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            e.val = {4'((k % 100) / 10), 4'(k % 10)};
            e.err = 1'b0;
            e.name = "cascade";
            sb.push_back(e);
            e.val = 8'(k % 16);
            e.name = "hex";
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check(e.name, 32'({q1, q0}), 32'(e.val));
            e = sb.pop_front();
            check(e.name, 32'(qh), 32'(e.val));
            @(negedge clk);
        end
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
